// File: rtl/uart_tx_arb.sv
// Round-robin, frame-granular arbiter sharing one UART byte transmitter among 4 sources.
// Optional LOAD timeout/abort is compiled in with `define ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter logic [15:0] MAX_FRAME   = 16'd256,
  parameter logic [15:0] TIMEOUT_LEN = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [3:0]  req,
  input  logic [31:0] src_data,
  input  logic [3:0]  src_valid,
  input  logic [3:0]  src_last,
  output logic [3:0]  src_ready,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  last_grant;
  logic [15:0] byte_cnt;
  logic        last_f;

  logic [1:0]  gidx;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        frame_end;

  // First requester after `last`, searching last+1 .. last+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    if (oh[3]) idx = 2'd3;
    return idx;
  endfunction

  assign gidx      = oh_to_idx(grant);
  assign sel_valid = src_valid[gidx];
  assign sel_last  = src_last[gidx];
  assign sel_data  = src_data[{gidx, 3'b000} +: 8];
  assign src_ready = (state == LOAD) ? grant : 4'b0000;
  assign frame_end = last_f || (byte_cnt == MAX_FRAME);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tout_cnt;
`else
  assign frame_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      byte_cnt    <= 16'd0;
      last_grant  <= 2'd3;
      last_f      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      frame_abort <= 1'b0;
      tout_cnt    <= 16'd0;
`endif
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      frame_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (init_done && |req) begin
            grant <= 4'b0001 << rr_pick(req, last_grant);
            state <= LOAD;
`ifdef ARB_TIMEOUT_EN
            tout_cnt <= 16'd0;
`endif
          end
        end
        LOAD: begin
          if (sel_valid) begin
            tx_data  <= sel_data;
            last_f   <= sel_last;
            byte_cnt <= byte_cnt + 16'd1;
            state    <= SEND;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tout_cnt + 16'd1 == TIMEOUT_LEN) begin
            frame_abort <= 1'b1;
            last_grant  <= gidx;
            grant       <= 4'b0000;
            byte_cnt    <= 16'd0;
            state       <= IDLE;
          end else begin
            tout_cnt <= tout_cnt + 16'd1;
          end
`endif
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= GUARD;
          end
        end
        // TX core raises busy one cycle after start; skip that cycle.
        GUARD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!tx_busy) begin
            if (frame_end) begin
              frame_done <= 1'b1;
              last_grant <= gidx;
              grant      <= 4'b0000;
              byte_cnt   <= 16'd0;
              state      <= IDLE;
            end else begin
              state <= LOAD;
`ifdef ARB_TIMEOUT_EN
              tout_cnt <= 16'd0;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: byte-queue sources, a busy-after-start TX model, logs of grants/bytes/frames.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [3:0]  req;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_last;
  logic [3:0]  src_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        frame_done;
  logic        frame_abort;

  always #5 clk = ~clk;

  uart_tx_arb #(.MAX_FRAME(16'd4), .TIMEOUT_LEN(16'd16)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ready(src_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .frame_done(frame_done),
    .frame_abort(frame_abort)
  );

  int checks = 0;
  int errors = 0;

  // Source byte queues: bit 8 = last flag.
  logic [8:0] mem [4][16];
  int         wr [4] = '{default: 0};
  int         rd [4] = '{default: 0};
  logic [3:0] xfer = 4'b0000;
  logic [3:0] req_extra = 4'b0000;

  always_comb begin
    src_valid = 4'b0000;
    src_last  = 4'b0000;
    src_data  = 32'h0;
    req       = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      src_valid[i]       = (rd[i] != wr[i]);
      src_data[8*i +: 8] = mem[i][rd[i][3:0]][7:0];
      src_last[i]        = mem[i][rd[i][3:0]][8];
      req[i]             = src_valid[i] | req_extra[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (xfer[i]) rd[i] <= rd[i] + 1;
  end

  // TX core: busy rises one cycle after start and lasts busy_len cycles.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start && busy_len > 0) begin
      busy_cnt <= busy_len;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  logic [7:0] txlog [64];
  logic [3:0] glog [64];
  int         ntx = 0;
  int         nfd = 0;
  int         ngl = 0;
  int         viol = 0;
  logic [3:0] gprev = 4'b0000;
  logic       start_prev = 1'b0;

  always @(posedge clk) begin
    xfer <= src_valid & src_ready;
    if (tx_start) begin
      txlog[ntx[5:0]] <= tx_data;
      ntx <= ntx + 1;
    end
    if (frame_done) nfd <= nfd + 1;
    if (grant != 4'b0000 && grant != gprev) begin
      glog[ngl[5:0]] <= grant;
      ngl <= ngl + 1;
    end
    gprev <= grant;
    if ((tx_start && tx_busy) || (tx_start && start_prev) || ((src_ready & ~grant) != 4'b0000))
      viol <= viol + 1;
    start_prev <= tx_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    mem[s][wr[s][3:0]] = {l, d};
    wr[s] = wr[s] + 1;
  endtask

  task automatic wait_fd(input int target, input string tag);
    for (int k = 0; k < 2000 && nfd < target; k++) @(negedge clk);
    chk(tag, nfd, target);
  endtask

  task automatic wait_tx(input int target, input string tag);
    for (int k = 0; k < 2000 && ntx < target; k++) @(negedge clk);
    chk(tag, ntx, target);
  endtask

  task automatic chk_bytes(input string tag, input int base, input logic [7:0] e [], input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), {24'h0, txlog[6'(base + i)]}, {24'h0, e[i]});
  endtask

  initial begin
    int bt, bf, bg;
    logic [7:0] e2 [];
    logic [7:0] e3 [];
    logic [7:0] e4 [];
    logic [7:0] e5 [];
    logic [3:0] g2 [5];
    logic [3:0] g4 [3];

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) mem[i][j] = 9'h0;
    rst = 1'b0;
    init_done = 1'b0;
    busy_len = 3;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    chk("rst_src_ready", src_ready, 4'b0000);

    // Held off by init_done while all four have frames pending
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(i, 8'(8'h10 * i + 8'h01), 1'b0);
      push(i, 8'(8'h10 * i + 8'h02), 1'b1);
    end
    push(0, 8'h03, 1'b0);
    push(0, 8'h04, 1'b1);
    repeat (5) @(negedge clk);
    chk("hold_grant", grant, 4'b0000);
    chk("hold_no_tx", ntx, 0);
    init_done = 1'b1;
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);

    // Round-robin order 0,1,2,3,0
    wait_fd(5, "rr_done_timeout");
    repeat (6) @(negedge clk);
    chk("rr_frame_count", nfd, 5);
    g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), glog[i], g2[i]);
    e2 = new[10];
    e2 = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
    chk_bytes("rr", 0, e2, 10);
    chk("rr_ntx", ntx, 10);

    // Slow TX core: 3 bytes from source 2
    bt = ntx; bf = nfd; bg = ngl;
    busy_len = 10;
    push(2, 8'hA5, 1'b0);
    push(2, 8'h5A, 1'b0);
    push(2, 8'hFF, 1'b1);
    wait_fd(bf + 1, "slow_done_timeout");
    repeat (3) @(negedge clk);
    chk("slow_ntx", ntx, bt + 3);
    e3 = new[3];
    e3 = '{8'hA5, 8'h5A, 8'hFF};
    chk_bytes("slow", bt, e3, 3);
    chk("slow_grant", glog[6'(bg)], 4'b0100);
    chk("slow_viol", viol, 0);

    // MAX_FRAME cut on source 1, then source 3 gets its turn
    bt = ntx; bf = nfd; bg = ngl;
    busy_len = 2;
    for (int i = 1; i <= 6; i++) push(1, 8'(8'h40 + i), (i == 6));
    for (int k = 0; k < 20 && grant != 4'b0010; k++) @(negedge clk);
    chk("max_grant1", grant, 4'b0010);
    push(3, 8'h50, 1'b1);
    wait_fd(bf + 3, "max_done_timeout");
    e4 = new[7];
    e4 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h50, 8'h45, 8'h46};
    chk_bytes("max", bt, e4, 7);
    g4 = '{4'b0010, 4'b1000, 4'b0010};
    for (int i = 0; i < 3; i++) chk($sformatf("max_grant_seq%0d", i), glog[6'(bg + i)], g4[i]);

    // init_done dropped mid-frame
    bt = ntx; bf = nfd;
    busy_len = 3;
    push(0, 8'h61, 1'b0);
    push(0, 8'h62, 1'b0);
    push(0, 8'h63, 1'b1);
    wait_tx(bt + 1, "init_first_byte_timeout");
    init_done = 1'b0;
    push(2, 8'h71, 1'b1);
    wait_fd(bf + 1, "init_done_timeout");
    repeat (10) @(negedge clk);
    chk("init_low_grant", grant, 4'b0000);
    chk("init_low_ntx", ntx, bt + 3);
    e5 = new[3];
    e5 = '{8'h61, 8'h62, 8'h63};
    chk_bytes("init", bt, e5, 3);
    init_done = 1'b1;
    @(negedge clk);
    chk("init_regrant", grant, 4'b0100);
    wait_fd(bf + 2, "init_second_timeout");
    chk("init_src2_byte", txlog[6'(bt + 3)], 8'h71);

    // Reset during WAIT
    bt = ntx; bf = nfd;
    busy_len = 10;
    push(3, 8'h81, 1'b0);
    push(3, 8'h82, 1'b1);
    wait_tx(bt + 1, "rstw_start_timeout");
    chk("rstw_pre_grant", grant, 4'b1000);
    rst = 1'b0;
    #1;
    chk("rstw_grant", grant, 4'b0000);
    chk("rstw_tx_data", tx_data, 8'h00);
    chk("rstw_tx_start", tx_start, 1'b0);
    chk("rstw_frame_done", frame_done, 1'b0);
    chk("rstw_src_ready", src_ready, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    wait_fd(bf + 1, "rstw_after_timeout");
    chk("rstw_ntx", ntx, bt + 2);
    chk("rstw_byte0", txlog[6'(bt)], 8'h81);
    chk("rstw_byte1", txlog[6'(bt + 1)], 8'h82);
    chk("rstw_regrant", glog[6'(ngl - 1)], 4'b1000);

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      req_extra = 4'b1000;
      for (int k = 0; k < 20 && grant != 4'b1000; k++) @(negedge clk);
      chk("tout_grant", grant, 4'b1000);
      n = 0;
      for (int k = 0; k < 40 && !frame_abort; k++) begin
        @(negedge clk);
        n++;
      end
      chk("tout_cycles", n, 16);
      chk("tout_grant_clear", grant, 4'b0000);
      req_extra = 4'b0000;
    end
`endif

    repeat (3) @(negedge clk);
    chk("protocol_viol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
